bst_key_inserter: RTL and testbench
===================================

// Module: bst_key_inserter
// PURPOSE
//  Consumes the 8-bit pseudo-random value stream from the LFSR generator and
//  builds a binary search tree of those keys in an internal node table.
//  A new key is detected when `random` changes value. Each key is inserted by
//  walking from the root node. Duplicate keys are counted and dropped.
//  Downstream display/traversal logic reads the finished tree through a
//  read-only table port.
// PARAMETERS
//  KEY_W   8   key width; must equal the generator output width
//  DEPTH   16  node table entries, power of two, >= 2
//  ADDR_W  $clog2(DEPTH)  node index width; derived, not overridden
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  random     in   KEY_W   generator output; a value change means a new key
//  enable     in   1       1 = accept keys; 0 = ignore value changes
//  clear      in   1       synchronous empty-tree command
//  busy       out  1       an insert walk is in progress
//  ins_done   out  1       1-cycle pulse when an insert or duplicate drop completes
//  full       out  1       node_count == DEPTH
//  node_count out  ADDR_W+1  number of occupied nodes
//  dup_cnt    out  8       duplicate keys dropped; saturates at 255
//  rd_addr    in   ADDR_W  table read index
//  rd_key     out  KEY_W   node key (combinational read)
//  rd_left    out  ADDR_W  left child index; 0 = none
//  rd_right   out  ADDR_W  right child index; 0 = none
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, prev_random=0, pending empty, table keys 0.
//  - Index 0 is always the root, so child pointer 0 means "no child".
//  - Key detect: when random != prev_random && enable, load random into a
//    1-deep pending register; prev_random <= random on every cycle.
//    A newer key overwrites a pending key that has not been taken yet.
//  - FSM states:
//    - IDLE: if pending && !full, take the key, cur=0, go to WALK, busy=1.
//      If node_count==0, write node0={key,0,0} and go to LINK_DONE.
//      If pending && full, drop the key with no counter change.
//    - WALK (1 cycle per level):
//      - key==node[cur].key: dup_cnt++ and go to LINK_DONE.
//      - key<node[cur].key: if left!=0 then cur=left; else write
//        node[node_count]={key,0,0}, left[cur]=node_count, go to LINK_DONE.
//      - key>node[cur].key: same as above, using right.
//    - LINK_DONE: node_count++ unless the key was a duplicate; ins_done=1;
//      busy=0; go to IDLE.
//  - Latency from pending to ins_done = tree depth along the path + 1 cycle.
//  - Comparisons are unsigned.
//  - full asserts the cycle after node_count reaches DEPTH. Keys arriving
//    while full are dropped.
//  - clear has priority over everything in any state: abort any walk,
//    node_count=0, pending empty, return to IDLE.
//    clear does not reset dup_cnt or table contents.
//  - enable deasserted mid-walk: the walk finishes; only new detection stops.
//  - Reset mid-walk: immediate return to the reset state; the partial
//    link is discarded.
// STRUCTURE
//  - bst_pkg: state enum (IDLE/WALK/LINK_DONE), NULL_IDX=0, KEY_W default.
//  - One sub-module, bst_node_ram: DEPTH x (KEY_W+2*ADDR_W) table with one
//    write port, one combinational read port for the walk, and one for rd_*.
//  - The FSM, pending register and counters live in the top level.
// TESTING
//  1. Reset with random=0x00 -> busy=0, full=0, node_count=0, dup_cnt=0.
//  2. Keys 0x80,0x40,0xC0 -> node0=80/L1/R2, node1=40, node2=C0,
//     node_count=3.
//  3. Key 0x40 again (via 0x41 then 0x40) -> 0x41 becomes node1.right=3,
//     then dup_cnt=1; the second ins_done comes after 2 WALK cycles + 1.
//  4. DEPTH=4 with 5 distinct keys -> full=1 after the 4th; the 5th is
//     dropped and node_count stays 4.
//  5. Assert clear during WALK -> node_count=0, busy=0 next cycle; the next
//     key becomes the root.
//  6. rst_n low mid-walk, then connect the LFSR generator (seed 0x0F) for
//     200 cycles -> the table matches a reference BST model built from the
//     same key sequence.

Source files
------------

// File: rtl/bst_pkg.sv
// Shared types and constants for the BST key inserter and its node table.
package bst_pkg;

  localparam int KEY_W_DEFAULT = 8;
  localparam int NULL_IDX      = 0;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WALK      = 2'd1,
    LINK_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bst_node_ram.sv
// Node table: one write port, one combinational read port for the walk and
// one for external readers. Every entry is cleared by reset.
module bst_node_ram #(
  parameter int KEY_W  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [ADDR_W-1:0] wr_left,
  input  logic [ADDR_W-1:0] wr_right,
  input  logic [ADDR_W-1:0] walk_addr,
  output logic [KEY_W-1:0]  walk_key,
  output logic [ADDR_W-1:0] walk_left,
  output logic [ADDR_W-1:0] walk_right,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [KEY_W-1:0]  rd_key,
  output logic [ADDR_W-1:0] rd_left,
  output logic [ADDR_W-1:0] rd_right
);

  logic [KEY_W-1:0]  key_mem   [DEPTH];
  logic [ADDR_W-1:0] left_mem  [DEPTH];
  logic [ADDR_W-1:0] right_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_mem[i]   <= '0;
        left_mem[i]  <= '0;
        right_mem[i] <= '0;
      end
    end else if (we) begin
      key_mem[wr_addr]   <= wr_key;
      left_mem[wr_addr]  <= wr_left;
      right_mem[wr_addr] <= wr_right;
    end
  end

  assign walk_key   = key_mem[walk_addr];
  assign walk_left  = left_mem[walk_addr];
  assign walk_right = right_mem[walk_addr];

  assign rd_key   = key_mem[rd_addr];
  assign rd_left  = left_mem[rd_addr];
  assign rd_right = right_mem[rd_addr];

endmodule

// File: rtl/bst_key_inserter.sv
// Builds a binary search tree from a changing key stream. The new node is
// written during WALK and its parent's child pointer in LINK_DONE, so the
// table needs only a single write port.
module bst_key_inserter
  import bst_pkg::*;
#(
  parameter  int KEY_W  = KEY_W_DEFAULT,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  random,
  input  logic              enable,
  input  logic              clear,
  output logic              busy,
  output logic              ins_done,
  output logic              full,
  output logic [ADDR_W:0]   node_count,
  output logic [7:0]        dup_cnt,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [KEY_W-1:0]  rd_key,
  output logic [ADDR_W-1:0] rd_left,
  output logic [ADDR_W-1:0] rd_right
);

  state_t            state;
  logic [KEY_W-1:0]  prev_random;
  logic              pend_valid;
  logic [KEY_W-1:0]  pend_key;
  logic [KEY_W-1:0]  key_reg;
  logic [ADDR_W-1:0] cur;
  logic              is_dup;
  logic              link_en;
  logic              link_left;

  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [KEY_W-1:0]  wr_key;
  logic [ADDR_W-1:0] wr_left;
  logic [ADDR_W-1:0] wr_right;
  logic [KEY_W-1:0]  walk_key;
  logic [ADDR_W-1:0] walk_left;
  logic [ADDR_W-1:0] walk_right;

  logic              detect;
  logic              at_cap;
  logic              go_left;
  logic              key_eq;
  logic [ADDR_W-1:0] child;
  logic [ADDR_W-1:0] new_idx;

  assign detect  = enable && (random != prev_random);
  // full lags node_count by a cycle, so admission uses the live count
  assign at_cap  = (node_count == (ADDR_W+1)'(DEPTH));
  assign key_eq  = (key_reg == walk_key);
  assign go_left = (key_reg < walk_key);
  assign child   = go_left ? walk_left : walk_right;
  assign new_idx = node_count[ADDR_W-1:0];

  bst_node_ram #(
    .KEY_W (KEY_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_key    (wr_key),
    .wr_left   (wr_left),
    .wr_right  (wr_right),
    .walk_addr (cur),
    .walk_key  (walk_key),
    .walk_left (walk_left),
    .walk_right(walk_right),
    .rd_addr   (rd_addr),
    .rd_key    (rd_key),
    .rd_left   (rd_left),
    .rd_right  (rd_right)
  );

  always_comb begin
    we       = 1'b0;
    wr_addr  = cur;
    wr_key   = key_reg;
    wr_left  = '0;
    wr_right = '0;
    unique case (state)
      IDLE: begin
        if (pend_valid && !at_cap && node_count == '0) begin
          we      = 1'b1;
          wr_addr = '0;
          wr_key  = pend_key;
        end
      end
      WALK: begin
        if (!key_eq && child == ADDR_W'(NULL_IDX)) begin
          we      = 1'b1;
          wr_addr = new_idx;
        end
      end
      LINK_DONE: begin
        if (link_en) begin
          we       = 1'b1;
          wr_key   = walk_key;
          wr_left  = link_left ? new_idx : walk_left;
          wr_right = link_left ? walk_right : new_idx;
        end
      end
      default: we = 1'b0;
    endcase
    if (clear) we = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prev_random <= '0;
      pend_valid  <= 1'b0;
      pend_key    <= '0;
      key_reg     <= '0;
      cur         <= '0;
      is_dup      <= 1'b0;
      link_en     <= 1'b0;
      link_left   <= 1'b0;
      busy        <= 1'b0;
      ins_done    <= 1'b0;
      full        <= 1'b0;
      node_count  <= '0;
      dup_cnt     <= '0;
    end else begin
      prev_random <= random;
      full        <= at_cap;
      if (clear) begin
        state      <= IDLE;
        pend_valid <= 1'b0;
        busy       <= 1'b0;
        ins_done   <= 1'b0;
        link_en    <= 1'b0;
        node_count <= '0;
      end else begin
        ins_done <= 1'b0;
        // IDLE consumes (or drops) whatever is pending unless a newer key lands
        if (detect) begin
          pend_valid <= 1'b1;
          pend_key   <= random;
        end else if (state == IDLE) begin
          pend_valid <= 1'b0;
        end
        unique case (state)
          IDLE: begin
            if (pend_valid && !at_cap) begin
              key_reg <= pend_key;
              cur     <= '0;
              is_dup  <= 1'b0;
              link_en <= 1'b0;
              busy    <= 1'b1;
              state   <= (node_count == '0) ? LINK_DONE : WALK;
            end
          end
          WALK: begin
            if (key_eq) begin
              is_dup <= 1'b1;
              if (dup_cnt != 8'hFF) dup_cnt <= dup_cnt + 8'd1;
              state  <= LINK_DONE;
            end else if (child != ADDR_W'(NULL_IDX)) begin
              cur <= child;
            end else begin
              link_en   <= 1'b1;
              link_left <= go_left;
              state     <= LINK_DONE;
            end
          end
          LINK_DONE: begin
            if (!is_dup) node_count <= node_count + 1'b1;
            link_en  <= 1'b0;
            ins_done <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bst_key_inserter.sv
// Scoreboard bench: a reference BST predicts walk length, node count and
// duplicate count for every insert, and the node table is compared afterwards.
module tb_bst_key_inserter;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rnd;
  logic          en, clr;
  logic          busy, ins_done, full;
  logic [AW:0]   node_count;
  logic [7:0]    dup_cnt;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_key;
  logic [AW-1:0] rd_left, rd_right;

  logic [7:0]    rnd4;
  logic          en4, clr4;
  logic          busy4, done4, full4;
  logic [2:0]    cnt4;
  logic [7:0]    dup4;
  logic [1:0]    rd_addr4;
  logic [7:0]    rd_key4;
  logic [1:0]    rd_left4, rd_right4;

  always #5 clk = ~clk;

  bst_key_inserter #(.KEY_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .random(rnd), .enable(en), .clear(clr),
    .busy(busy), .ins_done(ins_done), .full(full), .node_count(node_count),
    .dup_cnt(dup_cnt), .rd_addr(rd_addr), .rd_key(rd_key),
    .rd_left(rd_left), .rd_right(rd_right)
  );

  bst_key_inserter #(.KEY_W(8), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .random(rnd4), .enable(en4), .clear(clr4),
    .busy(busy4), .ins_done(done4), .full(full4), .node_count(cnt4),
    .dup_cnt(dup4), .rd_addr(rd_addr4), .rd_key(rd_key4),
    .rd_left(rd_left4), .rd_right(rd_right4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference tree
  int m_key [DEPTH];
  int m_l   [DEPTH];
  int m_r   [DEPTH];
  int m_cnt = 0;
  int m_dup = 0;

  typedef struct {
    int cycles;
    int cnt;
    int dup;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;
  int   busy_run = 0;

  task automatic model_insert(input int k);
    exp_t e;
    int   cur, depth;
    bit   fin, dup;
    dup = 0;
    if (m_cnt == 0) begin
      m_key[0] = k; m_l[0] = 0; m_r[0] = 0;
      m_cnt    = 1;
      e.cycles = 1;
    end else begin
      cur = 0; depth = 0; fin = 0;
      while (!fin) begin
        depth++;
        if (k == m_key[cur]) begin
          dup = 1; fin = 1;
        end else if (k < m_key[cur]) begin
          if (m_l[cur] != 0) cur = m_l[cur];
          else begin m_l[cur] = m_cnt; fin = 1; end
        end else begin
          if (m_r[cur] != 0) cur = m_r[cur];
          else begin m_r[cur] = m_cnt; fin = 1; end
        end
      end
      if (dup) begin
        if (m_dup < 255) m_dup++;
      end else begin
        m_key[m_cnt] = k; m_l[m_cnt] = 0; m_r[m_cnt] = 0;
        m_cnt++;
      end
      e.cycles = depth + 1;
    end
    e.cnt = m_cnt;
    e.dup = m_dup;
    exp_q.push_back(e);
  endtask

  // pop one expectation per ins_done and measure how long busy was high
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else if (ins_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e_mon = exp_q.pop_front();
        check("busy_cycles", busy_run, e_mon.cycles);
        check("node_count", int'(node_count), e_mon.cnt);
        check("dup_cnt", int'(dup_cnt), e_mon.dup);
        $display("[TB] insert done: count=%0d dup=%0d busy=%0d", node_count, dup_cnt, busy_run);
      end
      busy_run = 0;
    end else if (busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  task automatic send(input int k);
    @(negedge clk);
    rnd = 8'(k);
    model_insert(k);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_table();
    @(negedge clk);
    for (int i = 0; i < m_cnt; i++) begin
      rd_addr = AW'(i);
      #1;
      check($sformatf("node%0d_key", i), int'(rd_key), m_key[i]);
      check($sformatf("node%0d_left", i), int'(rd_left), m_l[i]);
      check($sformatf("node%0d_right", i), int'(rd_right), m_r[i]);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_cnt = 0;
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] r);
    return {r[6:0], r[7] ^ r[5] ^ r[4] ^ r[3]};
  endfunction

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] lr;
    int seen;
    rst_n = 1'b0; rnd = 8'h00; en = 1'b1; clr = 1'b0; rd_addr = '0;
    rnd4 = 8'h00; en4 = 1'b1; clr4 = 1'b0; rd_addr4 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // reset state
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_done", ins_done, 0);
    check("rst_count", int'(node_count), 0);
    check("rst_dup", int'(dup_cnt), 0);
    check("rst_key0", int'(rd_key), 0);

    // basic three-node tree, then a new right child and a duplicate
    send(8'h80); send(8'h40); send(8'hC0);
    check_table();
    send(8'h41); send(8'h40);
    check("dup_after_40", int'(dup_cnt), 1);
    check_table();

    // value changes with enable low are ignored
    en = 1'b0;
    @(negedge clk); rnd = 8'h90;
    repeat (6) @(negedge clk);
    check("en_off_count", int'(node_count), 4);
    check("en_off_busy", busy, 0);
    en = 1'b1;

    // clear during a walk
    @(negedge clk); rnd = 8'h30;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    check("walk_started", busy, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_count", int'(node_count), 0);
    check("clr_busy", busy, 0);
    m_cnt = 0;
    send(8'h55);
    check_table();

    // reset in the middle of a walk
    @(negedge clk); rnd = 8'h20;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    check("walk2_started", busy, 1);
    rst_n = 1'b0; rnd = 8'h00;
    #1;
    rd_addr = '0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", int'(node_count), 0);
    check("mid_rst_dup", int'(dup_cnt), 0);
    check("mid_rst_key0", int'(rd_key), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0; m_dup = 0;

    // DEPTH=4 instance: fills after four keys, fifth is dropped
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); rnd4 = 8'(k * 16);
      for (int i = 0; i < 30 && !done4; i++) @(negedge clk);
      check($sformatf("d4_done%0d", k), done4, 1);
      check($sformatf("d4_count%0d", k), int'(cnt4), k);
      $display("[TB] depth4 key 0x%0h count=%0d", k * 16, cnt4);
    end
    check("d4_full_lag", full4, 0);
    @(negedge clk);
    check("d4_full", full4, 1);
    rnd4 = 8'h50;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4 || busy4) seen = 1;
    end
    check("d4_drop_activity", seen, 0);
    check("d4_drop_count", int'(cnt4), 4);
    check("d4_drop_dup", int'(dup4), 0);
    rd_addr4 = 2'd2;
    #1;
    check("d4_node2_right", int'(rd_right4), 3);
    rd_addr4 = 2'd3;
    #1;
    check("d4_node3_key", int'(rd_key4), 8'h40);

    // LFSR key stream, clearing the tree whenever it fills
    lr = 8'h0F;
    for (int s = 0; s < 200; s++) begin
      if (m_cnt == DEPTH) begin
        check_table();
        do_clear();
      end
      send(int'(lr));
      lr = lfsr_next(lr);
    end
    check("lfsr_count", int'(node_count), m_cnt);
    check("lfsr_dup", int'(dup_cnt), m_dup);
    check_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
